// File: rtl/wb_burst_master.sv
// wb_burst_master
//   Wishbone burst master feeding the SDRAM controller's Wishbone slave.
//   Takes one command at a time (we, byte address, beats-1) and runs it as a
//   single Wishbone cycle: incrementing burst (cti 010 ... 111) or a classic
//   single beat (cti 000). Write data arrives on a valid/ready stream through
//   a one-entry hold register; read data leaves on a valid-only stream.
//
// Optional feature macro: WBM_TIMEOUT_EN
//   defined   -> ack watchdog; after TO_CYC strobed cycles without ack the
//                cycle is abandoned, err is set (sticky until next command)
//   undefined -> waits for ack forever, err is constant 0
//
// Ports
//   sys_clk, RESETN                 clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_we, cmd_addr, cmd_len       command fields (beats = cmd_len + 1)
//   wdat_valid/wdat_ready, wdat     write-data stream
//   rdat_valid, rdat                read-data stream (no backpressure)
//   wb_*                            Wishbone master signals
//   busy, done, err                 status: level, 1-cycle pulse, sticky
module wb_burst_master #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int BLW    = 8,
    parameter int TO_CYC = 255
) (
    input  logic            sys_clk,
    input  logic            RESETN,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [BLW-1:0]  cmd_len,
    input  logic            wdat_valid,
    output logic            wdat_ready,
    input  logic [DW-1:0]   wdat,
    output logic            rdat_valid,
    output logic [DW-1:0]   rdat,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [AW-1:0]  STEP  = AW'(DW / 8);
    localparam logic [BLW-1:0] CNT1  = BLW'(1);
    localparam logic [BLW:0]   FET1  = (BLW + 1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_END} state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [BLW-1:0]  r_len;
    logic [BLW-1:0]  r_cnt;        // beats remaining minus one
    logic [BLW:0]    r_fetched;    // write words pulled from the stream
    logic            r_hold_full;
    logic [DW-1:0]   r_hold;
    logic [DW-1:0]   r_rdat;
    logic            r_rdat_valid;

    logic            w_accept;
    logic            w_ack;
    logic            w_last;
    logic            w_wtake;
    logic            w_timeout;

    assign w_accept = cmd_valid & cmd_ready;
    assign w_ack    = wb_cyc_o & wb_stb_o & wb_ack_i;
    assign w_last   = w_ack & (r_cnt == '0);

    // Hold register refills in the same cycle its word is acked, so a
    // continuous stream with back-to-back acks sustains one beat per cycle.
    assign wdat_ready = (r_state == S_BURST) & r_we &
                        (r_fetched <= {1'b0, r_len}) &
                        (~r_hold_full | w_ack);
    assign w_wtake    = wdat_valid & wdat_ready;

    assign wb_addr_o  = r_addr;
    assign wb_dat_o   = r_hold;
    assign rdat       = r_rdat;
    assign rdat_valid = r_rdat_valid;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_next = S_BURST;
            S_BURST: if (w_last || w_timeout) w_next = S_END;
            S_END:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_sel_o  = '0;
        wb_cti_o  = 3'b000;
        case (r_state)
            S_IDLE: cmd_ready = 1'b1;
            S_BURST: begin
                busy     = 1'b1;
                wb_cyc_o = 1'b1;
                wb_we_o  = r_we;
                // writes only strobe when a word is actually held
                wb_stb_o = r_we ? r_hold_full : 1'b1;
                wb_sel_o = '1;
                if (r_len != '0)
                    wb_cti_o = (r_cnt == '0) ? 3'b111 : 3'b010;
            end
            S_END: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_fetched    <= '0;
            r_hold_full  <= 1'b0;
            r_hold       <= '0;
            r_rdat       <= '0;
            r_rdat_valid <= 1'b0;
        end else begin
            r_rdat_valid <= 1'b0;
            if (w_accept) begin
                r_we        <= cmd_we;
                r_addr      <= cmd_addr;
                r_len       <= cmd_len;
                r_cnt       <= cmd_len;
                r_fetched   <= '0;
                r_hold_full <= 1'b0;
            end else begin
                if (w_ack) begin
                    r_addr <= r_addr + STEP;
                    r_cnt  <= r_cnt - CNT1;
                    if (!r_we) begin
                        r_rdat       <= wb_dat_i;
                        r_rdat_valid <= 1'b1;
                    end
                end
                if (w_wtake) begin
                    r_hold      <= wdat;
                    r_hold_full <= 1'b1;
                    r_fetched   <= r_fetched + FET1;
                end else if (w_ack) begin
                    r_hold_full <= 1'b0;
                end
            end
        end
    end

`ifdef WBM_TIMEOUT_EN
    // Extra bit so the post-trip increment cannot wrap back into range.
    localparam int TOW = $clog2(TO_CYC + 1) + 1;

    logic [TOW-1:0] r_to_cnt;
    logic           r_err;

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_timeout)
                r_err <= 1'b1;
            if (wb_stb_o && !wb_ack_i)
                r_to_cnt <= r_to_cnt + TOW'(1);
            else if (wb_stb_o && wb_ack_i)
                r_to_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == S_BURST) && (r_to_cnt == TOW'(TO_CYC));
    assign err       = r_err;
`else
    assign w_timeout = 1'b0;
    // TO_CYC only matters with the watchdog; this folds to constant 0.
    assign err       = (TO_CYC < 0);
`endif

endmodule
